// File: rtl/ws2812_pkg.sv
// Shared types and default 12 MHz timing for the WS2812 line driver.
package ws2812_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_FETCH = 3'd2,
    ST_SHIFT = 3'd3,
    ST_RESET = 3'd4
  } state_e;

  localparam int unsigned WS_TBIT = 15;
  localparam int unsigned WS_T0H  = 5;
  localparam int unsigned WS_T1H  = 9;
  localparam int unsigned WS_TRES = 720;

endpackage

// File: rtl/ws2812_serializer.sv
// WS2812 bit serializer: requests 24-bit pixels, shifts them out MSB first as
// high/low pulse pairs, prefetches the next pixel, then holds the latch period.
module ws2812_serializer
  import ws2812_pkg::*;
#(
  parameter int unsigned TBIT = WS_TBIT,
  parameter int unsigned T0H  = WS_T0H,
  parameter int unsigned T1H  = WS_T1H,
  parameter int unsigned TRES = WS_TRES
) (
  input  logic        clk_sb,
  input  logic        reset_n,
  input  logic        send_leds_n,
  input  logic [23:0] rgb_data_in,
  output logic        ws2812_next_led,
  output logic        dout,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned PW = $clog2(TBIT);
  localparam int unsigned RW = (TRES > 1) ? $clog2(TRES) : 1;

  localparam logic [PW-1:0] PH_LAST = PW'(TBIT - 1);
  localparam logic [PW-1:0] T0H_C   = PW'(T0H);
  localparam logic [PW-1:0] T1H_C   = PW'(T1H);
  localparam logic [RW-1:0] RC_LAST = RW'(TRES - 1);

  if (!(T0H >= 1 && T0H < T1H && T1H < TBIT && TBIT >= 4 && TRES >= 1)) begin : g_bad_params
    $error("ws2812_serializer: illegal timing parameter set");
  end

  state_e        state_q;
  logic [PW-1:0] phase_q;
  logic [4:0]    bidx_q;
  logic [RW-1:0] rcnt_q;
  logic [23:0]   shreg_q;
  logic          pend_q, req_q, dout_q, busy_q, done_q;
  logic [PW-1:0] phase_inc;

  assign phase_inc = phase_q + 1'b1;

  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      bidx_q  <= '0;
      rcnt_q  <= '0;
      shreg_q <= '0;
      pend_q  <= 1'b0;
      req_q   <= 1'b0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      req_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          dout_q <= 1'b0;
          if (!send_leds_n) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_REQ: state_q <= ST_FETCH;
        ST_FETCH: begin
          shreg_q <= rgb_data_in;
          bidx_q  <= 5'd23;
          phase_q <= '0;
          dout_q  <= 1'b1;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (phase_q != PH_LAST) begin
            phase_q <= phase_inc;
            dout_q  <= (phase_inc < (shreg_q[23] ? T1H_C : T0H_C));
          end else begin
            phase_q <= '0;
            if (bidx_q != 5'd0) begin
              shreg_q <= {shreg_q[22:0], 1'b0};
              bidx_q  <= bidx_q - 1'b1;
              dout_q  <= 1'b1;
              // Request lands in phase 0 of the last bit, leaving a full bit time for the data.
              if (bidx_q == 5'd1 && !send_leds_n) begin
                req_q  <= 1'b1;
                pend_q <= 1'b1;
              end
            end else if (pend_q) begin
              shreg_q <= rgb_data_in;
              pend_q  <= 1'b0;
              bidx_q  <= 5'd23;
              dout_q  <= 1'b1;
            end else begin
              state_q <= ST_RESET;
              rcnt_q  <= '0;
              dout_q  <= 1'b0;
            end
          end
        end
        ST_RESET: begin
          dout_q <= 1'b0;
          if (rcnt_q == RC_LAST) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ws2812_next_led = req_q;
  assign dout            = dout_q;
  assign busy            = busy_q;
  assign frame_done      = done_q;

endmodule

// File: tb/tb_ws2812_serializer.sv
// Directed bench for ws2812_serializer: per-cycle waveform capture checked
// against a bit-timing model built from the pixel list.
module tb_ws2812_serializer;

  localparam int TB = 15;
  localparam int T0 = 5;
  localparam int T1 = 9;
  localparam int TR = 720;
  localparam int PIX_CYC = 24 * TB;

  logic        clk_sb = 1'b0;
  logic        reset_n;
  logic        send_leds_n;
  logic [23:0] rgb_data_in;
  logic        ws2812_next_led, dout, busy, frame_done;

  int n_chk = 0;
  int n_fail = 0;

  logic dq[$];
  logic rq[$];
  logic fq[$];
  logic bq[$];
  logic [23:0] pix [3];
  int done_idx;

  always #5 clk_sb = ~clk_sb;

  ws2812_serializer #(.TBIT(TB), .T0H(T0), .T1H(T1), .TRES(TR)) dut (
    .clk_sb(clk_sb), .reset_n(reset_n), .send_leds_n(send_leds_n),
    .rgb_data_in(rgb_data_in), .ws2812_next_led(ws2812_next_led),
    .dout(dout), .busy(busy), .frame_done(frame_done)
  );

  // Cycle 0 = IDLE cycle in which send_leds_n is first low.
  function automatic logic exp_dout(input int c, input int n);
    int t, p, b, ph;
    logic [23:0] w;
    if (c < 3 || c >= 3 + PIX_CYC * n) return 1'b0;
    t  = c - 3;
    p  = t / PIX_CYC;
    b  = (t % PIX_CYC) / TB;
    ph = t % TB;
    w  = pix[p];
    return (ph < (w[23-b] ? T1 : T0)) ? 1'b1 : 1'b0;
  endfunction

  // Upstream model: serves pix[] one cycle after each request, releases
  // send_leds_n after the n-th request unless rise_c selects a fixed cycle.
  task automatic run_frame(input int n, input int rise_c, input int relow_c);
    int nreq;
    nreq = 0;
    done_idx = -1;
    dq.delete(); rq.delete(); fq.delete(); bq.delete();
    rgb_data_in = 24'h5A5A5A;
    dq.push_back(dout); rq.push_back(ws2812_next_led);
    fq.push_back(frame_done); bq.push_back(busy);
    send_leds_n = 1'b0;
    for (int c = 1; c < 4000; c++) begin
      @(negedge clk_sb);
      dq.push_back(dout); rq.push_back(ws2812_next_led);
      fq.push_back(frame_done); bq.push_back(busy);
      if (ws2812_next_led) begin
        if (nreq < n) rgb_data_in = pix[nreq];
        nreq++;
        if (rise_c < 0 && nreq >= n) send_leds_n = 1'b1;
      end
      if (c == rise_c) send_leds_n = 1'b1;
      if (c == relow_c) send_leds_n = 1'b0;
      if (frame_done) begin
        done_idx = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; send_leds_n = 1'b1; rgb_data_in = '0;
    #1;
    n_chk++; if (dout !== 1'b0) begin n_fail++; $display("FAIL reset_dout got %b exp 0", dout); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_chk++; if (ws2812_next_led !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", ws2812_next_led); end
    n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", frame_done); end
    repeat (2) @(negedge clk_sb);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sb);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_one_pixel();
    int nr;
    pix[0] = 24'hA50000;
    run_frame(1, -1, -1);
    n_chk++; if (done_idx !== 3 + PIX_CYC + TR) begin n_fail++; $display("FAIL one_done_cycle got %0d exp %0d", done_idx, 3 + PIX_CYC + TR); end
    nr = 0;
    foreach (rq[i]) if (rq[i]) nr++;
    n_chk++; if (nr !== 1) begin n_fail++; $display("FAIL one_req_count got %0d exp 1", nr); end
    n_chk++; if (rq[1] !== 1'b1) begin n_fail++; $display("FAIL one_req_cycle1 got %b exp 1", rq[1]); end
    n_chk++; if (bq[0] !== 1'b0 || bq[1] !== 1'b1) begin n_fail++; $display("FAIL one_busy_start got %b%b exp 01", bq[0], bq[1]); end
    if (done_idx > 0) begin
      n_chk++; if (bq[done_idx] !== 1'b0 || bq[done_idx-1] !== 1'b1) begin
        n_fail++; $display("FAIL one_busy_end got %b%b exp 10", bq[done_idx-1], bq[done_idx]); end
    end
    foreach (dq[c]) begin
      n_chk++;
      if (dq[c] !== exp_dout(c, 1)) begin
        n_fail++; $display("FAIL one_dout cycle %0d got %b exp %b", c, dq[c], exp_dout(c, 1)); break;
      end
    end
  endtask

  task automatic test_back_to_back();
    int pos[$];
    int exp_pos[3];
    pix[0] = 24'hFFFFFF; pix[1] = 24'h000000; pix[2] = 24'h0F0F0F;
    exp_pos[0] = 1; exp_pos[1] = 3 + 23 * TB; exp_pos[2] = 3 + PIX_CYC + 23 * TB;
    run_frame(3, -1, -1);
    n_chk++; if (done_idx !== 3 + 3 * PIX_CYC + TR) begin n_fail++; $display("FAIL b2b_done_cycle got %0d exp %0d", done_idx, 3 + 3 * PIX_CYC + TR); end
    foreach (rq[i]) if (rq[i]) pos.push_back(i);
    n_chk++;
    if (pos.size() !== 3) begin
      n_fail++; $display("FAIL b2b_req_count got %0d exp 3", pos.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_chk++; if (pos[i] !== exp_pos[i]) begin n_fail++; $display("FAIL b2b_req_pos[%0d] got %0d exp %0d", i, pos[i], exp_pos[i]); end
      end
    end
    foreach (dq[c]) begin
      n_chk++;
      if (dq[c] !== exp_dout(c, 3)) begin
        n_fail++; $display("FAIL b2b_dout cycle %0d got %b exp %b", c, dq[c], exp_dout(c, 3)); break;
      end
    end
  endtask

  task automatic test_mid_release();
    int nr;
    pix[0] = 24'h123456;
    run_frame(1, 200, -1);
    n_chk++; if (done_idx !== 3 + PIX_CYC + TR) begin n_fail++; $display("FAIL mid_done_cycle got %0d exp %0d", done_idx, 3 + PIX_CYC + TR); end
    nr = 0;
    foreach (rq[i]) if (rq[i]) nr++;
    n_chk++; if (nr !== 1) begin n_fail++; $display("FAIL mid_req_count got %0d exp 1", nr); end
    foreach (dq[c]) begin
      n_chk++;
      if (dq[c] !== exp_dout(c, 1)) begin
        n_fail++; $display("FAIL mid_dout cycle %0d got %b exp %b", c, dq[c], exp_dout(c, 1)); break;
      end
    end
  endtask

  task automatic test_hold_low();
    int nr;
    pix[0] = 24'hC3C3C3;
    run_frame(1, -1, 3 + PIX_CYC + 7);
    n_chk++; if (done_idx !== 3 + PIX_CYC + TR) begin n_fail++; $display("FAIL hold_done_cycle got %0d exp %0d", done_idx, 3 + PIX_CYC + TR); end
    nr = 0;
    foreach (rq[i]) if (rq[i]) nr++;
    n_chk++; if (nr !== 1) begin n_fail++; $display("FAIL hold_req_in_reset got %0d pulses exp 1", nr); end
    @(negedge clk_sb);
    n_chk++; if (ws2812_next_led !== 1'b1) begin n_fail++; $display("FAIL hold_new_req got %b exp 1", ws2812_next_led); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_new_busy got %b exp 1", busy); end
    send_leds_n = 1'b1;
    reset_n = 1'b0;
    @(negedge clk_sb);
    reset_n = 1'b1;
    @(negedge clk_sb);
  endtask

  task automatic test_reset_mid_frame();
    int nreq;
    pix[0] = 24'h000000; pix[1] = 24'hFFFFFF;
    nreq = 0;
    rgb_data_in = 24'h5A5A5A;
    send_leds_n = 1'b0;
    for (int c = 1; c <= 3 + PIX_CYC + 10 * TB + 3; c++) begin
      @(negedge clk_sb);
      if (ws2812_next_led) begin
        if (nreq < 2) rgb_data_in = pix[nreq];
        nreq++;
        if (nreq >= 2) send_leds_n = 1'b1;
      end
    end
    n_chk++; if (dout !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre dout/busy got %b/%b exp 1/1", dout, busy); end
    reset_n = 1'b0;
    #1;
    n_chk++; if (dout !== 1'b0) begin n_fail++; $display("FAIL rst_async_dout got %b exp 0", dout); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got %b exp 0", busy); end
    n_chk++; if (ws2812_next_led !== 1'b0) begin n_fail++; $display("FAIL rst_async_req got %b exp 0", ws2812_next_led); end
    send_leds_n = 1'b1;
    @(negedge clk_sb);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sb);
    pix[0] = 24'h400000;
    run_frame(1, -1, -1);
    n_chk++; if (rq[1] !== 1'b1) begin n_fail++; $display("FAIL restart_req got %b exp 1", rq[1]); end
    n_chk++; if (dq[2] !== 1'b0 || dq[3] !== 1'b1) begin n_fail++; $display("FAIL restart_first_high got %b%b exp 01", dq[2], dq[3]); end
    n_chk++; if (done_idx !== 3 + PIX_CYC + TR) begin n_fail++; $display("FAIL restart_done_cycle got %0d exp %0d", done_idx, 3 + PIX_CYC + TR); end
    foreach (dq[c]) begin
      n_chk++;
      if (dq[c] !== exp_dout(c, 1)) begin
        n_fail++; $display("FAIL restart_dout cycle %0d got %b exp %b", c, dq[c], exp_dout(c, 1)); break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_pixel();
    @(negedge clk_sb);
    test_back_to_back();
    @(negedge clk_sb);
    test_mid_release();
    @(negedge clk_sb);
    test_hold_low();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ws2812_serializer.md
# ws2812_serializer

Bit-level WS2812 line driver sitting directly downstream of the serial-bus translator. While `send_leds_n` is low it requests one 24-bit pixel at a time with a single-cycle `ws2812_next_led` pulse and captures the pixel from `rgb_data_in`. It shifts each pixel out MSB first as WS2812 high/low pulse pairs. When the translator releases `send_leds_n`, it finishes the current pixel, drives the line low for the latch/reset period, and then returns to idle.

## Interface
- `TBIT`, 15: cycles per bit (1.25 µs at 12 MHz).
- `T0H`, 5: high cycles for a 0 bit.
- `T1H`, 9: high cycles for a 1 bit.
- `TRES`, 720: low cycles for the latch period (60 µs at 12 MHz).
- Legal parameter set: 1 ≤ T0H < T1H < TBIT, TBIT ≥ 4, TRES ≥ 1. Check at elaboration.

- `clk_sb`  in  1  system clock; one clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `send_leds_n`  in  1  active low; low = frame in progress, more pixels available.
- `rgb_data_in`  in  24  pixel word. Valid in the cycle after `ws2812_next_led` is high.
- `ws2812_next_led`  out  1  one-cycle pixel request pulse.
- `dout`  out  1  serial WS2812 data line, registered.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse on leaving RESET.

## Operation
- Reset value of every output is 0. State = IDLE, all counters and the shift register = 0.
- **States:** IDLE, REQ, FETCH, SHIFT, RESET.
- **IDLE:** `dout`=0. If `send_leds_n`=0 → REQ.
- **REQ:** `ws2812_next_led`=1 for exactly this cycle → FETCH.
- **FETCH:** on the closing edge, load `shreg` ← `rgb_data_in`, bit index ← 23, phase ← 0. → SHIFT.
- **SHIFT:**
  - `dout` = 1 while phase < (`shreg`[23] ? T1H : T0H), else 0.
  - Phase counts 0..TBIT-1. At TBIT-1, shift left by one and decrement the bit index.
- **Prefetch:** at phase 0 of bit index 0, if `send_leds_n`=0, pulse `ws2812_next_led` and set `pend`. If `send_leds_n`=1, do not pulse.
- **End of bit index 0** (phase TBIT-1):
  - If `pend`: load `shreg` ← `rgb_data_in`, clear `pend`, bit index ← 23, stay in SHIFT. No gap between pixels.
  - Else → RESET, counter ← 0.
- **RESET:** `dout`=0 for TRES cycles. Ignore `send_leds_n`. On the last cycle, pulse `frame_done` and go → IDLE.
- `send_leds_n` is sampled only in IDLE and at phase 0 of bit index 0. Changes at any other time have no effect on the pixel being shifted.
- A pixel is always sent whole. A rise of `send_leds_n` mid-pixel does not truncate it.
- Reset asserted mid-frame: all outputs drop to 0 immediately (asynchronously). The line stays low, so the next frame still sees a valid latch interval as long as the pause is ≥ TRES in real time. Restart is from IDLE.
- **Widths:** phase counter $clog2(TBIT), bit index 5 bits, reset counter $clog2(TRES). No counter may wrap.

## Timing
- From `send_leds_n` low seen in IDLE (cycle 0): REQ at cycle 1, FETCH at cycle 2, first `dout` high at cycle 3.
- **Upstream contract:** `rgb_data_in` must hold the new pixel from the cycle after the request pulse until the next request. For prefetch requests it must be stable at least 1 cycle before the end of the last bit.
- **Per-pixel period:** exactly 24·TBIT cycles, back to back.
- **Frame length:** N pixels occupy 3 + 24·TBIT·N + TRES cycles from the start to `frame_done`.
- **Request count:** exactly N pulses for a frame where `send_leds_n` is seen low N times (1 start + N-1 prefetches).

## Structure
- Shared package `ws2812_pkg` holds:
  - the state enum (IDLE, REQ, FETCH, SHIFT, RESET);
  - default timing constants at 12 MHz (TBIT, T0H, T1H, TRES).
- Single flat module, no sub-module. The counters are small and tightly coupled to the FSM.

## Test plan
- **One pixel:** `send_leds_n` low 1 cycle after IDLE, `rgb_data_in`=24'hA50000. `send_leds_n` rises after the first request.
  - Expect 1 request pulse.
  - Bits 1,0,1,0,0,1,0,1 then 16 zeros, with high widths 9/5 cycles and period 15.
  - Then 720 low cycles, then `frame_done`.
- **Three pixels back-to-back** (FFFFFF, 000000, 0F0F0F), model upstream updating the data 1 cycle after each pulse.
  - Expect 3 pulses, the 2nd and 3rd at phase 0 of the last bit.
  - No gap between pixels; total frame length 3 + 1080 + 720 cycles.
- **`send_leds_n` raised mid-pixel:** the current pixel completes all 24 bits, no further request, then RESET.
- **`send_leds_n` held low through RESET:** requests stay 0 for all 720 cycles. A new REQ follows 1 cycle after `frame_done`.
- **`reset_n` pulsed at bit 10 of pixel 2:** `dout`, `busy` and `ws2812_next_led` are 0 immediately. After release, `send_leds_n` low restarts with a first `dout` high 3 cycles later.
